// File: rtl/rv32i_types.sv
// Shared types for the rv32i memory subsystem.
package rv32i_types;
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} arb_state_t;
  typedef enum logic {ICACHE, DCACHE} arb_src_t;
endpackage

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing the single L2 line port between I-cache and D-cache,
// one transaction at a time, with forced idle cycles after each response.
module l2_arbiter
  import rv32i_types::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  i_addr,
  input  logic         i_read,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic [31:0]  d_addr,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic [31:0]  mem_addr,
  output logic         mem_read,
  output logic         mem_write,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  input  logic         mem_resp
);

  arb_state_t state;
  arb_src_t   owner, last, pick;
  logic [3:0] cnt;
  logic       i_pend, d_pend, busy_resp;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;
  // On a tie, the side that was not served last wins.
  assign pick = (i_pend && d_pend) ? ((last == ICACHE) ? DCACHE : ICACHE)
                                   : (i_pend ? ICACHE : DCACHE);

  assign busy_resp = mem_resp && (state == BUSY);
  assign i_resp    = busy_resp && (owner == ICACHE);
  assign d_resp    = busy_resp && (owner == DCACHE);
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= ICACHE;
      last      <= DCACHE;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_pend || d_pend) begin
            state <= BUSY;
            owner <= pick;
            last  <= pick;
            if (pick == ICACHE) begin
              mem_addr  <= i_addr;
              mem_read  <= 1'b1;
              mem_write <= 1'b0;
              mem_wdata <= '0;
            end else begin
              // Read+write together is illegal; treat it as a writeback.
              mem_addr  <= d_addr;
              mem_read  <= d_read & ~d_write;
              mem_write <= d_write;
              mem_wdata <= d_wdata;
            end
          end
        end
        BUSY: begin
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            cnt       <= 4'(DRAIN_CYCLES);
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed self-checking bench for l2_arbiter.
module tb_l2_arbiter;
  logic         clk, rst_n;
  logic [31:0]  i_addr, d_addr, mem_addr;
  logic         i_read, i_resp, d_read, d_write, d_resp;
  logic         mem_read, mem_write, mem_resp;
  logic [255:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;

  int passed = 0;
  int total  = 0;

  localparam logic [255:0] AA = {8{32'hAAAA_AAAA}};
  localparam logic [255:0] FIVES = {8{32'h5555_5555}};

  l2_arbiter #(.DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Respond, drop all requests, and wait until the arbiter is back in IDLE.
  task automatic finish_txn();
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    repeat (2) step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_resp = 1'b1;
    #1;
    total++; if (mem_read !== 1'b0) $display("FAIL reset mem_read got %0b exp 0", mem_read); else passed++;
    total++; if (mem_write !== 1'b0) $display("FAIL reset mem_write got %0b exp 0", mem_write); else passed++;
    total++; if (mem_addr !== 32'h0) $display("FAIL reset mem_addr got %h exp 0", mem_addr); else passed++;
    total++; if (mem_wdata !== 256'h0) $display("FAIL reset mem_wdata got %h exp 0", mem_wdata); else passed++;
    total++; if ({i_resp, d_resp} !== 2'b00) $display("FAIL reset resp got %b exp 00", {i_resp, d_resp}); else passed++;
    mem_resp = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_icache_read();
    i_addr = 32'h0000_1000; i_read = 1'b1;
    step();
    total++; if (mem_read !== 1'b1) $display("FAIL iread mem_read got %0b exp 1", mem_read); else passed++;
    total++; if (mem_addr !== 32'h1000) $display("FAIL iread mem_addr got %h exp 1000", mem_addr); else passed++;
    total++; if (mem_wdata !== 256'h0) $display("FAIL iread mem_wdata got %h exp 0", mem_wdata); else passed++;
    step();
    mem_rdata = AA; mem_resp = 1'b1;
    #1;
    total++; if (i_resp !== 1'b1) $display("FAIL iread i_resp got %0b exp 1", i_resp); else passed++;
    total++; if (i_rdata !== AA) $display("FAIL iread i_rdata got %h exp aa..", i_rdata); else passed++;
    total++; if (d_resp !== 1'b0) $display("FAIL iread d_resp got %0b exp 0", d_resp); else passed++;
    step();
    mem_resp = 1'b0; i_read = 1'b0;
    total++; if (mem_read !== 1'b0) $display("FAIL iread mem_read after resp got %0b exp 0", mem_read); else passed++;
    repeat (2) step();
    total++; if (mem_read !== 1'b0) $display("FAIL iread duplicate grant got %0b exp 0", mem_read); else passed++;
  endtask

  task automatic test_tie();
    apply_reset();
    i_addr = 32'h3000; i_read = 1'b1;
    d_addr = 32'h2000; d_write = 1'b1; d_wdata = FIVES;
    step();
    total++; if (mem_addr !== 32'h3000 || mem_read !== 1'b1) $display("FAIL tie first got addr %h rd %0b exp 3000/1", mem_addr, mem_read); else passed++;
    mem_resp = 1'b1;
    #1;
    total++; if ({i_resp, d_resp} !== 2'b10) $display("FAIL tie i resp got %b exp 10", {i_resp, d_resp}); else passed++;
    step();
    mem_resp = 1'b0; i_read = 1'b0;
    step();
    step();
    total++; if (mem_write !== 1'b0) $display("FAIL tie write during drain got %0b exp 0", mem_write); else passed++;
    step();
    total++; if (mem_write !== 1'b1 || mem_read !== 1'b0) $display("FAIL tie d write got wr %0b rd %0b exp 1/0", mem_write, mem_read); else passed++;
    total++; if (mem_addr !== 32'h2000) $display("FAIL tie d addr got %h exp 2000", mem_addr); else passed++;
    total++; if (mem_wdata !== FIVES) $display("FAIL tie d wdata got %h exp 55..", mem_wdata); else passed++;
    mem_resp = 1'b1;
    #1;
    total++; if ({i_resp, d_resp} !== 2'b01) $display("FAIL tie d resp got %b exp 01", {i_resp, d_resp}); else passed++;
    step();
    mem_resp = 1'b0;
    repeat (2) step();
    i_read = 1'b1; i_addr = 32'h3100; d_write = 1'b1;
    step();
    total++; if (mem_addr !== 32'h3100 || mem_read !== 1'b1) $display("FAIL tie second got addr %h rd %0b exp 3100/1", mem_addr, mem_read); else passed++;
    finish_txn();
  endtask

  task automatic test_back_to_back();
    int n;
    d_addr = 32'h4000; d_read = 1'b1;
    step();
    for (int t = 0; t < 2; t++) begin
      total++; if (mem_read !== 1'b1) $display("FAIL b2b grant %0d got %0b exp 1", t, mem_read); else passed++;
      mem_resp = 1'b1;
      #1;
      total++; if (d_resp !== 1'b1) $display("FAIL b2b d_resp %0d got %0b exp 1", t, d_resp); else passed++;
      step();
      mem_resp = 1'b0;
      n = 0;
      while (mem_read !== 1'b1 && n < 10) begin
        total++; if (d_resp !== 1'b0) $display("FAIL b2b extra d_resp got %0b exp 0", d_resp); else passed++;
        step();
        n++;
      end
      total++; if (n != 3) $display("FAIL b2b gap %0d got %0d exp 3", t, n); else passed++;
    end
    finish_txn();
  endtask

  task automatic test_rw_conflict_spurious();
    d_addr = 32'h5000; d_read = 1'b1; d_write = 1'b1; d_wdata = FIVES;
    step();
    total++; if (mem_write !== 1'b1 || mem_read !== 1'b0) $display("FAIL rw got wr %0b rd %0b exp 1/0", mem_write, mem_read); else passed++;
    mem_resp = 1'b1;
    step();
    d_read = 1'b0; d_write = 1'b0;
    #1;
    total++; if ({i_resp, d_resp} !== 2'b00) $display("FAIL spurious drain resp got %b exp 00", {i_resp, d_resp}); else passed++;
    repeat (3) step();
    total++; if ({i_resp, d_resp} !== 2'b00) $display("FAIL spurious idle resp got %b exp 00", {i_resp, d_resp}); else passed++;
    total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) $display("FAIL spurious idle request got %b exp 00", {mem_read, mem_write}); else passed++;
    mem_resp = 1'b0;
  endtask

  task automatic test_withdraw();
    i_addr = 32'h6000; i_read = 1'b1;
    step();
    i_read = 1'b0; i_addr = 32'h7000;
    step();
    total++; if (mem_addr !== 32'h6000 || mem_read !== 1'b1) $display("FAIL withdraw got addr %h rd %0b exp 6000/1", mem_addr, mem_read); else passed++;
    step();
    mem_resp = 1'b1;
    #1;
    total++; if (i_resp !== 1'b1) $display("FAIL withdraw i_resp got %0b exp 1", i_resp); else passed++;
    step();
    mem_resp = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset_mid_busy();
    d_addr = 32'h8000; d_read = 1'b1;
    step();
    total++; if (mem_read !== 1'b1) $display("FAIL rstbusy grant got %0b exp 1", mem_read); else passed++;
    #1 rst_n = 1'b0;
    #1;
    total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) $display("FAIL rstbusy async drop got %b exp 00", {mem_read, mem_write}); else passed++;
    d_read = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    mem_resp = 1'b1;
    #1;
    total++; if ({i_resp, d_resp} !== 2'b00) $display("FAIL rstbusy stale resp got %b exp 00", {i_resp, d_resp}); else passed++;
    mem_resp = 1'b0;
    i_addr = 32'h9000; i_read = 1'b1;
    step();
    total++; if (mem_read !== 1'b1 || mem_addr !== 32'h9000) $display("FAIL rstbusy regrant got rd %0b addr %h exp 1/9000", mem_read, mem_addr); else passed++;
    mem_resp = 1'b1;
    #1;
    total++; if (i_resp !== 1'b1) $display("FAIL rstbusy i_resp got %0b exp 1", i_resp); else passed++;
    mem_resp = 1'b0;
    finish_txn();
  endtask

  initial begin
    rst_n = 1'b0;
    i_addr = '0; i_read = 1'b0;
    d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    test_reset();
    test_icache_read();
    test_tie();
    test_back_to_back();
    test_rw_conflict_spurious();
    test_withdraw();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
